// File: rtl/printer_pkg.sv
// Shared printer constants: 40 MHz step/dir timing defaults, per-axis travel
// limits and the error-flag payload used by the step/dir receivers.
package printer_pkg;

  localparam int unsigned POS_W_DEF         = 16;
  localparam int unsigned DIR_SETUP_CYC     = 8;
  localparam int unsigned MIN_PULSE_CYC     = 40;
  localparam int unsigned IDLE_CYC_DEF      = 400000;

  localparam int unsigned POS_MAX_X         = 20000;
  localparam int unsigned POS_MAX_Y         = 20000;
  localparam int unsigned POS_MAX_Z         = 20000;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_e;

  typedef struct packed {
    logic setup;
    logic pulse;
    logic limit;
  } err_flags_t;

  // Travel limit for a given axis once it has been homed.
  function automatic int unsigned axis_pos_max(input axis_e axis);
    case (axis)
      AXIS_Y:  return POS_MAX_Y;
      AXIS_Z:  return POS_MAX_Z;
      default: return POS_MAX_X;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a third stage for registered rise/fall pulses.
// Edges are only reported once a genuine low has been sampled after reset.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_vld;
  logic       r_armed;
  logic       r_rise;
  logic       r_fall;

  // r_vld tracks which stages hold real samples; a level held high across
  // reset must fall and rise again before it produces an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= i_async;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_s2) begin
        r_armed <= 1'b1;
      end
      r_rise  <= r_s2 & ~r_s3 & r_armed;
      r_fall  <= ~r_s2 & r_s3 & r_armed;
    end
  end

  assign o_level = r_s3;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/stepdir_decoder.sv
// Single-axis step/direction receiver: tracks absolute position, flags
// step-protocol violations and reports motion activity.
module stepdir_decoder
  import printer_pkg::*;
#(
  parameter int unsigned POS_W     = POS_W_DEF,
  parameter int unsigned POS_MAX   = axis_pos_max(AXIS_X),
  parameter int unsigned DIR_SETUP = DIR_SETUP_CYC,
  parameter int unsigned MIN_PULSE = MIN_PULSE_CYC,
  parameter int unsigned IDLE_CYC  = IDLE_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    home_in,
  input  logic                    clr_err,
  output logic signed [POS_W-1:0] pos,
  output logic                    pos_valid,
  output logic                    homed,
  output logic                    moving,
  output logic                    setup_err,
  output logic                    pulse_err,
  output logic                    limit_err
);

  localparam int unsigned DS_W = $clog2(DIR_SETUP + 1);
  localparam int unsigned PW_W = $clog2(MIN_PULSE + 1);
  localparam int unsigned ID_W = $clog2(IDLE_CYC + 1);

  logic w_step_lvl;
  logic w_step_rise;
  logic w_step_fall;
  logic w_dir_lvl;
  logic w_dir_rise_unused;
  logic w_dir_fall_unused;
  logic w_home_lvl;
  logic w_home_rise_unused;
  logic w_home_fall_unused;

  sync_edge_detect u_sync_step (
    .clk     (clk),
    .rst     (rst),
    .i_async (step_in),
    .o_level (w_step_lvl),
    .o_rise  (w_step_rise),
    .o_fall  (w_step_fall)
  );

  sync_edge_detect u_sync_dir (
    .clk     (clk),
    .rst     (rst),
    .i_async (dir_in),
    .o_level (w_dir_lvl),
    .o_rise  (w_dir_rise_unused),
    .o_fall  (w_dir_fall_unused)
  );

  sync_edge_detect u_sync_home (
    .clk     (clk),
    .rst     (rst),
    .i_async (home_in),
    .o_level (w_home_lvl),
    .o_rise  (w_home_rise_unused),
    .o_fall  (w_home_fall_unused)
  );

  logic signed [POS_W-1:0] r_pos;
  logic                    r_pos_valid;
  logic                    r_homed;
  logic                    r_moving;
  logic                    r_dir_q;
  logic [DS_W-1:0]         r_dir_cnt;
  logic [PW_W-1:0]         r_pw_cnt;
  logic [ID_W-1:0]         r_idle_cnt;
  err_flags_t              r_err;

  logic signed [POS_W-1:0] w_pos_nxt;
  logic                    w_pos_valid_nxt;
  logic                    w_homed_nxt;
  logic [DS_W-1:0]         w_dir_cnt_nxt;
  logic [PW_W-1:0]         w_pw_cnt_nxt;
  logic [ID_W-1:0]         w_idle_cnt_nxt;
  logic                    w_moving_nxt;
  err_flags_t              w_err_evt;
  err_flags_t              w_err_nxt;
  logic                    w_dir_chg;
  logic                    w_dir_ok;
  logic                    w_step_taken;
  logic                    w_at_max;
  logic                    w_at_min;

  assign w_dir_chg    = w_dir_lvl ^ r_dir_q;
  assign w_dir_ok     = !w_dir_chg && (r_dir_cnt >= DS_W'(DIR_SETUP));
  assign w_step_taken = w_step_rise && !w_home_lvl;
  assign w_at_max     = (r_pos == POS_W'(POS_MAX));
  assign w_at_min     = (r_pos == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos       <= '0;
      r_pos_valid <= 1'b0;
      r_homed     <= 1'b0;
      r_moving    <= 1'b0;
      r_dir_q     <= 1'b0;
      r_dir_cnt   <= '0;
      r_pw_cnt    <= '0;
      r_idle_cnt  <= '0;
      r_err       <= '0;
    end else begin
      r_pos       <= w_pos_nxt;
      r_pos_valid <= w_pos_valid_nxt;
      r_homed     <= w_homed_nxt;
      r_moving    <= w_moving_nxt;
      r_dir_q     <= w_dir_lvl;
      r_dir_cnt   <= w_dir_cnt_nxt;
      r_pw_cnt    <= w_pw_cnt_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state: position, homing, counters and error events.
  always_comb begin
    w_pos_nxt       = r_pos;
    w_pos_valid_nxt = 1'b0;
    w_homed_nxt     = r_homed;
    w_err_evt       = '0;
    w_dir_cnt_nxt   = r_dir_cnt;
    w_pw_cnt_nxt    = '0;
    w_idle_cnt_nxt  = '0;

    if (w_dir_chg) begin
      w_dir_cnt_nxt = '0;
    end else if (r_dir_cnt < DS_W'(DIR_SETUP)) begin
      w_dir_cnt_nxt = r_dir_cnt + DS_W'(1);
    end

    if (w_step_lvl) begin
      w_pw_cnt_nxt = (r_pw_cnt < PW_W'(MIN_PULSE)) ? r_pw_cnt + PW_W'(1) : r_pw_cnt;
    end
    w_err_evt.pulse = w_step_fall && (r_pw_cnt < PW_W'(MIN_PULSE));

    // Home switch overrides any step in flight.
    if (w_home_lvl) begin
      w_pos_nxt   = '0;
      w_homed_nxt = 1'b1;
    end else if (w_step_rise) begin
      w_err_evt.setup = !w_dir_ok;
      if (r_homed && ((w_dir_lvl && w_at_max) || (!w_dir_lvl && w_at_min))) begin
        w_err_evt.limit = 1'b1;
      end else begin
        w_pos_nxt       = w_dir_lvl ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
        w_pos_valid_nxt = 1'b1;
      end
    end

    if (w_step_taken) begin
      w_idle_cnt_nxt = ID_W'(IDLE_CYC);
    end else if (r_idle_cnt != '0) begin
      w_idle_cnt_nxt = r_idle_cnt - ID_W'(1);
    end
    w_moving_nxt = (w_idle_cnt_nxt != '0);

    // A new event in the same cycle as clr_err keeps its flag set.
    w_err_nxt.setup = (r_err.setup & ~clr_err) | w_err_evt.setup;
    w_err_nxt.pulse = (r_err.pulse & ~clr_err) | w_err_evt.pulse;
    w_err_nxt.limit = (r_err.limit & ~clr_err) | w_err_evt.limit;
  end

  assign pos       = r_pos;
  assign pos_valid = r_pos_valid;
  assign homed     = r_homed;
  assign moving    = r_moving;
  assign setup_err = r_err.setup;
  assign pulse_err = r_err.pulse;
  assign limit_err = r_err.limit;

endmodule
